cipher_uart_tx: RTL

Serialising transmitter that sits directly downstream of `cpu_pipeline` and carries its 128-bit `cipher_output` off-chip over an 8N1 UART line. A 128-bit block is accepted on a valid/ready handshake and latched. It is then sent as 16 bytes, most-significant byte first, with no idle gap between frames. A one-cycle `done` pulse marks the end of the block; the transmitter then returns to idle and accepts the next block.

---
 rtl/cipher_uart_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// cipher_uart_tx
//
// Serialises one 128-bit cipher block onto a UART line. The block goes out as
// 16 back-to-back frames, most-significant byte first, LSB first within each
// byte. A one-cycle done pulse marks the return to idle.
//
// Build option: define CIPHER_UART_PARITY_EN to insert an even-parity bit after
// d7 (8E1, 11 bits per frame). Without it the line format is 8N1.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   cipher_valid  a block is offered on cipher_data
//   cipher_data   128-bit block to transmit
//   cipher_ready  block can be accepted (high only while idle)
//   tx            registered UART serial output, idles high
//   busy          a block is being transmitted
//   done          one-cycle pulse after the last stop bit of byte 15
//
// Handshake: a block transfers on a rising edge where cipher_valid and
// cipher_ready are both high. cipher_ready depends only on internal state,
// never on cipher_valid. An offer made while cipher_ready is low is dropped,
// not queued; the source must keep it valid until it sees the transfer.
// -----------------------------------------------------------------------------
module cipher_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cipher_valid,
   input  logic [127:0] cipher_data,
   output logic         cipher_ready,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef CIPHER_UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   // state is kept as a plain named register so external checkers can bind to it
   state_t             state,    state_n;
   logic [127:0]       shreg,    shreg_n;
   logic [CNT_W-1:0]   baud_cnt, cnt_n;
   logic [2:0]         bit_idx,  bit_n;
   logic [3:0]         byte_idx, byte_n;
   logic               tx_n;
   logic               done_n;

   logic [7:0]         cur_byte;
   logic               bit_last;
   logic [2:0]         bit_nxt;

   // The byte on the wire is always the top byte; the register shifts left
   // by one byte at each frame boundary.
   assign cur_byte     = shreg[127:120];
   assign bit_last     = (baud_cnt == CNT_LAST);
   assign bit_nxt      = bit_idx + 3'd1;

   assign busy         = (state != S_IDLE);
   assign cipher_ready = (state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         shreg    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         baud_cnt <= cnt_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         tx       <= tx_n;
         done     <= done_n;
      end
   end

   // tx_n is the line level for the bit that starts at the coming edge, so tx
   // and state change on the same edge and each bit lasts CLKS_PER_BIT cycles.
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = baud_cnt + CNT_W'(1);
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      tx_n    = tx;
      done_n  = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
            if (cipher_valid) begin
               shreg_n = cipher_data;
               byte_n  = 4'd0;
               bit_n   = 3'd0;
               state_n = S_START;
               tx_n    = 1'b0;
            end
         end

         S_START: begin
            if (bit_last) begin
               cnt_n   = '0;
               bit_n   = 3'd0;
               state_n = S_DATA;
               tx_n    = cur_byte[0];
            end
         end

         S_DATA: begin
            if (bit_last) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) begin
`ifdef CIPHER_UART_PARITY_EN
                  state_n = S_PARITY;
                  tx_n    = ^cur_byte;
`else
                  state_n = S_STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n = bit_nxt;
                  tx_n  = cur_byte[bit_nxt];
               end
            end
         end

`ifdef CIPHER_UART_PARITY_EN
         S_PARITY: begin
            if (bit_last) begin
               cnt_n   = '0;
               state_n = S_STOP;
               tx_n    = 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (bit_last) begin
               cnt_n = '0;
               if (byte_idx == 4'd15) begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
                  tx_n    = 1'b1;
               end else begin
                  byte_n  = byte_idx + 4'd1;
                  shreg_n = {shreg[119:0], 8'h00};
                  state_n = S_START;
                  tx_n    = 1'b0;
               end
            end
         end

         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule
